adc_drdy_scheduler: RTL and testbench

Parametrised DRDY capture and read scheduler for the ADC daisy-chain front end. It accepts CH_NUM asynchronous active-low DRDYOUT lines, synchronises them and latches each falling edge as a pending request. It then grants a single shared ADC read engine, either round-robin per channel or as aligned frames across all enabled chains. It sits between the DRDYOUT pins and the SPI/FIFO read path inside AHBLITE_SYS, and adds overrun detection, channel masking and frame timeout.

---
 rtl/adc_drdy_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_adc_drdy_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_drdy_scheduler.sv
// -----------------------------------------------------------------------------
// adc_drdy_scheduler
//
// Captures falling edges on CH_NUM asynchronous, active-low DRDYOUT lines and
// schedules a single shared ADC read engine. Mode 0 serves channels one at a
// time in round-robin order. Mode 1 collects an aligned frame across all
// enabled chains, then serves the captured channels in ascending order.
//
// Ports:
//   sys_clk, sys_rst  clock and synchronous active-high reset
//   drdy_n            asynchronous DRDYOUT lines, idle high
//   ch_enable         per-channel enable; a disabled channel drops its pending
//   mode              0 = round-robin, 1 = aligned frame (sampled in IDLE)
//   timeout_cfg       aligned-mode collect limit in cycles, 0 = no limit
//   rd_req, rd_ch     registered read request and granted channel
//   rd_ack            one-cycle pulse, read of rd_ch complete
//   pending           pending DRDY flags
//   overrun           sticky overrun flags, cleared by overrun_clr
//   frame_start       pulse, aligned frame issue begins
//   frame_done        pulse, last ack of an aligned frame seen
//   timeout_flag      pulse, frame was issued because the collect timed out
//   busy              scheduler FSM not in IDLE
// -----------------------------------------------------------------------------
module adc_drdy_scheduler #(
  parameter int CH_NUM      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [CH_NUM-1:0]    drdy_n,
  input  logic [CH_NUM-1:0]    ch_enable,
  input  logic                 mode,
  input  logic [TIMEOUT_W-1:0] timeout_cfg,
  output logic                 rd_req,
  output logic [CH_W-1:0]      rd_ch,
  input  logic                 rd_ack,
  output logic [CH_NUM-1:0]    pending,
  output logic [CH_NUM-1:0]    overrun,
  input  logic [CH_NUM-1:0]    overrun_clr,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 timeout_flag,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [CH_NUM-1:0] pending_vec;
  logic [CH_NUM-1:0] overrun_vec;
  logic [CH_NUM-1:0] grant_clr;

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser, edge detector and pending/overrun flags.
  // The synchroniser and the previous-value flop reset to 1 so that a line
  // held low through reset produces exactly one edge after release.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   prev_reg;
      logic                   edge_reg;
      logic                   pend_reg;
      logic                   ovr_reg;
      logic                   set_pend;
      logic                   ovr_set;

      // A grant clearing the flag in the same cycle as a new edge is not an
      // overrun: the old request is being consumed as the new one arrives.
      assign set_pend = edge_reg & ch_enable[gi];
      assign ovr_set  = set_pend & pend_reg & ~grant_clr[gi];

      always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
          sync_reg <= '1;
          prev_reg <= 1'b1;
          edge_reg <= 1'b0;
          pend_reg <= 1'b0;
          ovr_reg  <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], drdy_n[gi]};
          prev_reg <= sync_reg[SYNC_STAGES-1];
          edge_reg <= prev_reg & ~sync_reg[SYNC_STAGES-1];

          if (set_pend) begin
            pend_reg <= 1'b1;
          end else if (grant_clr[gi] || !ch_enable[gi]) begin
            pend_reg <= 1'b0;
          end

          if (ovr_set) begin
            ovr_reg <= 1'b1;
          end else if (overrun_clr[gi]) begin
            ovr_reg <= 1'b0;
          end
        end
      end

      assign pending_vec[gi] = pend_reg;
      assign overrun_vec[gi] = ovr_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Scheduler datapath registers
  // ---------------------------------------------------------------------------
  logic                 mode_reg;
  logic [CH_W-1:0]      last_grant_reg, last_grant_next;
  logic [CH_W-1:0]      rd_ch_reg, rd_ch_next;
  logic                 rd_req_reg, rd_req_next;
  logic [CH_NUM-1:0]    snap_reg, snap_next;
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  logic                 frame_start_reg, frame_start_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 timeout_reg, timeout_next;

  logic [CH_NUM-1:0]    active;
  logic [CH_NUM-1:0]    snap_live;
  logic                 all_ready;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 to_hit;

  assign active    = pending_vec & ch_enable;
  assign snap_live = snap_reg & ch_enable;
  assign all_ready = (active == ch_enable);
  assign cnt_inc   = cnt_reg + 1'b1;
  // The collect phase lasts exactly timeout_cfg cycles: the limit is hit on
  // the cycle whose increment brings the counter up to timeout_cfg.
  assign to_hit    = (timeout_cfg != '0) && (cnt_inc == timeout_cfg);

  // Round-robin pick: lowest active channel above last_grant, otherwise the
  // lowest active channel at or below it (wrap-around).
  logic [CH_W-1:0] up_sel, wrap_sel, rr_sel, lo_sel, sel;
  logic            up_found, wrap_found, rr_found, lo_found, sel_found;
  logic [CH_NUM-1:0] sel_onehot, rd_ch_onehot;

  always_comb begin
    up_sel     = '0;
    wrap_sel   = '0;
    lo_sel     = '0;
    up_found   = 1'b0;
    wrap_found = 1'b0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (active[k] && (CH_W'(k) > last_grant_reg)) begin
        up_found = 1'b1;
        up_sel   = CH_W'(k);
      end
      if (active[k] && (CH_W'(k) <= last_grant_reg)) begin
        wrap_found = 1'b1;
        wrap_sel   = CH_W'(k);
      end
      if (snap_live[k]) begin
        lo_sel = CH_W'(k);
      end
    end
    rr_found  = up_found | wrap_found;
    rr_sel    = up_found ? up_sel : wrap_sel;
    lo_found  = |snap_live;
    sel_found = mode_reg ? lo_found : rr_found;
    sel       = mode_reg ? lo_sel : rr_sel;
  end

  always_comb begin
    sel_onehot   = '0;
    rd_ch_onehot = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      sel_onehot[k]   = (sel == CH_W'(k));
      rd_ch_onehot[k] = (rd_ch_reg == CH_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. mode is only looked at in IDLE; later states use
  // the copy latched while idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (|pending_vec) begin
          state_next = mode ? COLLECT : ISSUE;
        end
      end
      COLLECT: begin
        if (all_ready || to_hit) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // Nothing left to grant can happen when enables drop underneath us.
        if (sel_found) begin
          state_next = WAIT_ACK;
        end else begin
          state_next = mode_reg ? FRAME_END : IDLE;
        end
      end
      WAIT_ACK: begin
        if (rd_ack) begin
          if (!mode_reg) begin
            state_next = IDLE;
          end else if ((snap_live & ~rd_ch_onehot) == '0) begin
            state_next = FRAME_END;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      FRAME_END: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs and datapath)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_req_next      = (state_next == WAIT_ACK);
    rd_ch_next       = rd_ch_reg;
    grant_clr        = '0;
    frame_start_next = 1'b0;
    timeout_next     = 1'b0;
    frame_done_next  = (state_next == FRAME_END);
    snap_next        = snap_live;
    cnt_next         = cnt_reg;
    last_grant_next  = last_grant_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
      end
      COLLECT: begin
        cnt_next = cnt_inc;
        if (state_next == ISSUE) begin
          snap_next        = active;
          frame_start_next = 1'b1;
          timeout_next     = ~all_ready;
        end
      end
      ISSUE: begin
        if (state_next == WAIT_ACK) begin
          rd_ch_next = sel;
          grant_clr  = sel_onehot;
        end
      end
      WAIT_ACK: begin
        if (rd_ack) begin
          snap_next = snap_live & ~rd_ch_onehot;
          if (!mode_reg) begin
            last_grant_next = rd_ch_reg;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_reg        <= 1'b0;
      last_grant_reg  <= CH_W'(CH_NUM - 1);
      rd_ch_reg       <= '0;
      rd_req_reg      <= 1'b0;
      snap_reg        <= '0;
      cnt_reg         <= '0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        mode_reg <= mode;
      end
      last_grant_reg  <= last_grant_next;
      rd_ch_reg       <= rd_ch_next;
      rd_req_reg      <= rd_req_next;
      snap_reg        <= snap_next;
      cnt_reg         <= cnt_next;
      frame_start_reg <= frame_start_next;
      frame_done_reg  <= frame_done_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign rd_req       = rd_req_reg;
  assign rd_ch        = rd_ch_reg;
  assign pending      = pending_vec;
  assign overrun      = overrun_vec;
  assign frame_start  = frame_start_reg;
  assign frame_done   = frame_done_reg;
  assign timeout_flag = timeout_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_adc_drdy_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adc_drdy_scheduler
//
// Directed bench for adc_drdy_scheduler (CH_NUM=8, SYNC_STAGES=2). Round-robin
// grant order is driven from a table of {setup grant, edge mask, expected
// order} records; edge latency, overrun, masking, aligned frames and reset are
// covered by hand-written sequences. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adc_drdy_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  drdy_n;
  logic [7:0]  ch_enable;
  logic        mode;
  logic [15:0] timeout_cfg;
  logic        rd_req;
  logic [2:0]  rd_ch;
  logic        rd_ack;
  logic [7:0]  pending;
  logic [7:0]  overrun;
  logic [7:0]  overrun_clr;
  logic        frame_start;
  logic        frame_done;
  logic        timeout_flag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  adc_drdy_scheduler #(
    .CH_NUM     (8),
    .SYNC_STAGES(2),
    .TIMEOUT_W  (16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .drdy_n      (drdy_n),
    .ch_enable   (ch_enable),
    .mode        (mode),
    .timeout_cfg (timeout_cfg),
    .rd_req      (rd_req),
    .rd_ch       (rd_ch),
    .rd_ack      (rd_ack),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          has_pre;  // grant 'pre' first to position last_grant
    logic [2:0]  pre;
    logic [7:0]  mask;     // channels whose lines fall together
    int          n;        // number of grants expected
    logic [31:0] order;    // nibble g = channel of grant g
    int          dly;      // cycles from rd_req to rd_ack
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst     = 1'b1;
    drdy_n      = 8'hFF;
    rd_ack      = 1'b0;
    overrun_clr = 8'h00;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [7:0] mask);
    drdy_n = drdy_n & ~mask;
    repeat (3) tick();
    drdy_n = drdy_n | mask;
    repeat (3) tick();
  endtask

  task automatic wait_req(input string name, output bit ok);
    int n;
    n = 0;
    while (rd_req !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    ok = (rd_req === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: rd_req timeout, got 0, expected 1", name);
    end
  endtask

  task automatic serve(input logic [2:0] exp_ch, input int dly, input string name);
    bit ok;
    wait_req(name, ok);
    if (ok) begin
      check(name, {29'd0, rd_ch}, {29'd0, exp_ch});
      repeat (dly) tick();
      check({name, "_hold"}, {31'd0, rd_req}, 32'd1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check({name, "_drop"}, {31'd0, rd_req}, 32'd0);
    end
  endtask

  initial begin
    int n;
    int k;
    logic [31:0] ord;
    logic [2:0]  m1_order [7];

    vecs[0] = '{1'b0, 3'd0, 8'h01, 1, 32'h0000_0000, 4};
    vecs[1] = '{1'b1, 3'd5, 8'hA4, 3, 32'h0000_0527, 1};
    vecs[2] = '{1'b0, 3'd0, 8'hFF, 8, 32'h7654_3210, 0};
    vecs[3] = '{1'b1, 3'd7, 8'h81, 2, 32'h0000_0070, 2};
    vecs[4] = '{1'b1, 3'd3, 8'h19, 3, 32'h0000_0304, 1};
    vecs[5] = '{1'b1, 3'd0, 8'h03, 2, 32'h0000_0001, 3};

    mode        = 1'b0;
    ch_enable   = 8'hFF;
    timeout_cfg = 16'd100;

    // ---- reset values ----
    sys_rst = 1'b1;
    drdy_n = 8'hFF; rd_ack = 1'b0; overrun_clr = 8'h00;
    repeat (2) tick();
    check("reset_outputs",
          {8'd0, rd_req, rd_ch, pending, overrun, frame_start, frame_done, timeout_flag, busy}, 32'd0);
    sys_rst = 1'b0;
    tick();

    // ---- edge latency and first grant, mode 0 ----
    drdy_n = 8'hFE;
    tick(); tick(); tick();
    drdy_n = 8'hFF;
    check("lat_pending_early", {24'd0, pending}, 32'h00);
    tick();
    check("lat_pending", {24'd0, pending}, 32'h01);
    tick();
    check("lat_req_early", {31'd0, rd_req}, 32'd0);
    check("lat_busy", {31'd0, busy}, 32'd1);
    tick();
    check("lat_req", {31'd0, rd_req}, 32'd1);
    check("lat_ch", {29'd0, rd_ch}, 32'd0);
    check("lat_pending_cleared", {24'd0, pending}, 32'h00);
    repeat (4) tick();
    check("lat_hold", {31'd0, rd_req}, 32'd1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("lat_drop", {31'd0, rd_req}, 32'd0);
    check("lat_overrun", {24'd0, overrun}, 32'h00);

    // ---- round-robin order table ----
    for (int v = 0; v < 6; v++) begin
      mode = 1'b0;
      ch_enable = 8'hFF;
      do_reset();
      if (vecs[v].has_pre) begin
        pulse(8'h01 << vecs[v].pre);
        serve(vecs[v].pre, 1, $sformatf("rr%0d_pre", v));
        repeat (3) tick();
      end
      pulse(vecs[v].mask);
      ord = vecs[v].order;
      for (int g = 0; g < vecs[v].n; g++) begin
        serve(ord[4*g +: 3], vecs[v].dly, $sformatf("rr%0d_grant%0d", v, g));
      end
      repeat (4) tick();
      check($sformatf("rr%0d_idle", v), {15'd0, busy, pending, overrun}, 32'd0);
    end

    // ---- overrun, overrun_clr, edge on the grant cycle ----
    do_reset();
    pulse(8'h08);
    serve_no_ack_check: begin
      bit ok;
      wait_req("ovr_grant1", ok);
      check("ovr_grant1_ch", {29'd0, rd_ch}, 32'd3);
    end
    pulse(8'h08);
    pulse(8'h08);
    check("ovr_pending", {24'd0, pending}, 32'h08);
    check("ovr_flag", {24'd0, overrun}, 32'h08);
    overrun_clr = 8'h08;
    tick();
    overrun_clr = 8'h00;
    check("ovr_clr", {24'd0, overrun}, 32'h00);
    drdy_n[3] = 1'b0;
    tick();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    tick();
    drdy_n[3] = 1'b1;
    tick();
    check("ovr_setwins_pending", {24'd0, pending}, 32'h08);
    check("ovr_setwins_overrun", {24'd0, overrun}, 32'h00);
    check("ovr_regrant", {28'd0, rd_req, rd_ch}, 32'h0B);
    serve(3'd3, 1, "ovr_grant2");
    serve(3'd3, 1, "ovr_grant3");
    repeat (4) tick();
    check("ovr_final", {15'd0, busy, pending, overrun}, 32'd0);

    // ---- channel masking ----
    ch_enable = 8'hFB;
    do_reset();
    pulse(8'h24);
    begin
      bit ok;
      wait_req("mask_grant", ok);
      check("mask_grant_ch", {29'd0, rd_ch}, 32'd5);
    end
    check("mask_disabled_ignored", {24'd0, pending}, 32'h00);
    pulse(8'h40);
    check("mask_pending6", {24'd0, pending}, 32'h40);
    ch_enable = 8'hBB;
    tick();
    check("mask_drop_clears", {24'd0, pending}, 32'h00);
    ch_enable = 8'hFF;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    n = 0;
    while (rd_req !== 1'b1 && n < 10) begin tick(); n++; end
    check("mask_no_grant", {31'd0, rd_req}, 32'd0);

    // ---- aligned frame closed by timeout, channel 6 missing ----
    mode = 1'b1;
    ch_enable = 8'hFF;
    timeout_cfg = 16'd100;
    do_reset();
    drdy_n = 8'h40;
    repeat (3) tick();
    drdy_n = 8'hFF;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin tick(); n++; end
    check("m1_busy", {31'd0, busy}, 32'd1);
    k = 0;
    while (frame_start !== 1'b1 && k < 300) begin tick(); k++; end
    check("m1_timeout_cycles", k, 32'd100);
    check("m1_timeout_flag", {31'd0, timeout_flag}, 32'd1);
    tick();
    check("m1_pulses_low", {30'd0, frame_start, timeout_flag}, 32'd0);
    check("m1_first_req", {28'd0, rd_req, rd_ch}, 32'h08);
    m1_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    for (int g = 0; g < 7; g++) begin
      serve(m1_order[g], g % 3, $sformatf("m1_grant%0d", g));
      if (g == 0) check("m1_no_early_done", {31'd0, frame_done}, 32'd0);
      if (g == 2) pulse(8'h40);
    end
    check("m1_frame_done", {31'd0, frame_done}, 32'd1);
    check("m1_late_pending6", {24'd0, pending}, 32'h40);
    tick();
    check("m1_frame_done_pulse", {31'd0, frame_done}, 32'd0);
    k = 0;
    while (frame_start !== 1'b1 && k < 300) begin tick(); k++; end
    check("m1_next_frame_timeout", {30'd0, frame_start, timeout_flag}, 32'd3);
    serve(3'd6, 0, "m1_next_grant");
    check("m1_next_done", {31'd0, frame_done}, 32'd1);

    // ---- aligned frame, all channels within 10 cycles ----
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drdy_n[c] = 1'b0;
      tick();
    end
    n = 0;
    while (frame_start !== 1'b1 && n < 50) begin
      tick();
      n++;
      if (n == 3) drdy_n = 8'hFF;
    end
    drdy_n = 8'hFF;
    check("m1all_frame_start", {31'd0, frame_start}, 32'd1);
    check("m1all_no_timeout", {31'd0, timeout_flag}, 32'd0);
    for (int g = 0; g < 8; g++) begin
      serve(g[2:0], (g == 4) ? 3 : 0, $sformatf("m1all_grant%0d", g));
      if (g == 6) check("m1all_no_early_done", {31'd0, frame_done}, 32'd0);
    end
    check("m1all_frame_done", {31'd0, frame_done}, 32'd1);

    // ---- reset during WAIT_ACK with lines held low ----
    mode = 1'b0;
    do_reset();
    drdy_n = 8'hFD;
    begin
      bit ok;
      wait_req("rst_grant", ok);
      check("rst_grant_ch", {29'd0, rd_ch}, 32'd1);
    end
    drdy_n = 8'hED;
    tick(); tick();
    sys_rst = 1'b1;
    tick();
    check("rst_mid_outputs",
          {8'd0, rd_req, rd_ch, pending, overrun, frame_start, frame_done, timeout_flag, busy}, 32'd0);
    repeat (2) tick();
    sys_rst = 1'b0;
    tick(); tick(); tick();
    check("rst_rel_early", {24'd0, pending}, 32'h00);
    tick();
    check("rst_rel_pending", {24'd0, pending}, 32'h12);
    serve(3'd1, 1, "rst_grant_a");
    serve(3'd4, 1, "rst_grant_b");
    n = 0;
    while (rd_req !== 1'b1 && n < 30) begin tick(); n++; end
    check("rst_single_edge", {31'd0, rd_req}, 32'd0);
    check("rst_final_pending", {24'd0, pending}, 32'h00);
    drdy_n = 8'hFF;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
